// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int unsigned P_CPU      = 0;
  localparam int unsigned P_LD       = 1;
  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic {ST_OPEN, ST_LOCKED} arb_state_e;
endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick; under lock only the loader port can win.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (lock_i) begin
      gnt_o[P_LD] = req_i[P_LD];
    end else if (&req_i) begin
      // tie goes to the port that did not win last time
      if (last_i) gnt_o[P_CPU] = 1'b1;
      else        gnt_o[P_LD]  = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU MEM stage (port 0) and loader (port 1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LOCK_TO   = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  input  logic                   lock1_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   err_o,
  output logic                   stall0_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic [DATA_W-1:0]      mem_rdata_i
);

  localparam int unsigned TMR_W = $clog2(LOCK_TO + 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0]        pick;
  logic              granted, sel, sel_we, bad;
  logic [ADDR_W-1:0] sel_addr;

  dmem_rr_pick u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .lock_i (state_q == ST_LOCKED),
    .gnt_o  (pick)
  );

  always_comb begin
    // grants are combinational, so hold them off while reset is asserted
    gnt_o    = pick & {2{rst_i}};
    granted  = |gnt_o;
    sel      = gnt_o[P_LD];
    sel_addr = addr_i[sel];
    sel_we   = we_i[sel];
    bad      = (sel_addr[1:0] != 2'b00) ||
               ((sel_addr >> WORD_SHIFT) >= ADDR_W'(MEM_WORDS));

    mem_addr_o  = granted ? sel_addr : '0;
    mem_wdata_o = granted ? wdata_i[sel] : '0;
    mem_read_o  = granted & ~sel_we & ~bad;
    mem_write_o = granted & sel_we & ~bad;
    stall0_o    = req_i[P_CPU] & ~gnt_o[P_CPU];

    rvalid_d    = gnt_o;
    err_d       = granted & bad;
    rdata_d     = mem_read_o ? mem_rdata_i : '0;
    stall_cnt_d = (stall0_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    state_d = state_q;
    last_d  = granted ? sel : last_q;
    timer_d = timer_q;
    case (state_q)
      ST_OPEN: begin
        if (gnt_o[P_LD] && lock1_i) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end
      end
      ST_LOCKED: begin
        if (gnt_o[P_LD]) begin
          timer_d = '0;
          if (!lock1_i) state_d = ST_OPEN;
        end else if (!req_i[P_LD]) begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_d == TMR_W'(LOCK_TO)) begin
            state_d = ST_OPEN;
            last_d  = 1'b1;
            timer_d = '0;
          end
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_OPEN;
      last_q      <= 1'b1;
      timer_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
